// File: rtl/pipe_stage_skid_latch.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Flush squashes held entries; out_ctrl shows CTRL_BUBBLE whenever the stage is empty.
module pipe_stage_skid_latch #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_FIELDS = 3,
  parameter int unsigned CTRL_WIDTH = 7,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = {CTRL_WIDTH{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*NUM_FIELDS-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_FIELDS-1:0] out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  input  logic                             flush,
  output logic [1:0]                       occupancy
);

  localparam int unsigned PW = DATA_WIDTH * NUM_FIELDS;

  logic [PW-1:0]         main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic                  main_valid;
  logic [PW-1:0]         skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic                  skid_valid;
  logic                  accept;
  logic                  consume;

  // in_ready comes straight from the skid flag, so upstream never sees a path from out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & ~skid_valid;
  assign consume  = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data  <= '0;
      main_ctrl  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the in-flight entry in skid.
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid_latch.sv
// Bench for pipe_stage_skid_latch: directed vector table, async-reset and bubble sequences,
// and a random valid/ready stream on a narrow instance checked against a queue.
module tb_pipe_stage_skid_latch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
  logic [47:0] in_data = '0, out_data;
  logic [6:0]  in_ctrl = '0, out_ctrl;
  logic [1:0]  occupancy;

  // instance with non-zero bubble
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [47:0] b_in_data = '0, b_out_data;
  logic [6:0]  b_in_ctrl = '0, b_out_ctrl;
  logic [1:0]  b_occupancy;

  // narrow instance for the random stream
  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic [7:0]  s_in_data = '0, s_out_data;
  logic [0:0]  s_in_ctrl = '0, s_out_ctrl;
  logic [1:0]  s_occupancy;

  pipe_stage_skid_latch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .flush(flush), .occupancy(occupancy)
  );

  pipe_stage_skid_latch #(.CTRL_BUBBLE(7'h10)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_ctrl(b_in_ctrl), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .flush(1'b0), .occupancy(b_occupancy)
  );

  pipe_stage_skid_latch #(.DATA_WIDTH(8), .NUM_FIELDS(1), .CTRL_WIDTH(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_ctrl(s_in_ctrl), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .flush(1'b0), .occupancy(s_occupancy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        iv;
    logic [47:0] id;
    logic [6:0]  ic;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [47:0] od;
    logic [6:0]  oc;
    logic        ir;
    logic [1:0]  occ;
  } vec_t;

  localparam logic [47:0] A  = 48'h1234_5678_9ABC;
  localparam logic [47:0] AA = 48'hAAAA_0000_AAAA;
  localparam logic [47:0] BB = 48'hBBBB_0000_BBBB;
  localparam logic [47:0] CC = 48'hCCCC_0000_CCCC;
  localparam logic [47:0] DD = 48'hDDDD_0000_DDDD;
  localparam logic [47:0] EE = 48'hEEEE_0000_EEEE;

  vec_t vecs[25];

  initial begin
    // inputs applied before an edge | expected outputs right after that edge
    vecs[0]  = '{1'b1, A,      7'h15, 1'b1, 1'b0, 1'b1, A,      7'h15, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 48'd1,  7'h01, 1'b1, 1'b0, 1'b1, 48'd1,  7'h01, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 48'd2,  7'h02, 1'b1, 1'b0, 1'b1, 48'd2,  7'h02, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 48'd3,  7'h03, 1'b1, 1'b0, 1'b1, 48'd3,  7'h03, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 48'd4,  7'h04, 1'b1, 1'b0, 1'b1, 48'd4,  7'h04, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b0, 48'd4,  7'h00, 1'b1, 2'd0};
    vecs[6]  = '{1'b1, AA,     7'h0A, 1'b0, 1'b0, 1'b1, AA,     7'h0A, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, BB,     7'h0B, 1'b0, 1'b0, 1'b1, AA,     7'h0A, 1'b0, 2'd2};
    vecs[8]  = '{1'b1, CC,     7'h0C, 1'b0, 1'b0, 1'b1, AA,     7'h0A, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b1, BB,     7'h0B, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b0, BB,     7'h00, 1'b1, 2'd0};
    vecs[11] = '{1'b1, DD,     7'h0D, 1'b0, 1'b0, 1'b1, DD,     7'h0D, 1'b1, 2'd1};
    vecs[12] = '{1'b1, EE,     7'h0E, 1'b0, 1'b0, 1'b1, DD,     7'h0D, 1'b0, 2'd2};
    vecs[13] = '{1'b1, CC,     7'h0C, 1'b0, 1'b1, 1'b0, DD,     7'h00, 1'b1, 2'd0};
    vecs[14] = '{1'b1, 48'h11, 7'h11, 1'b1, 1'b1, 1'b0, DD,     7'h00, 1'b1, 2'd0};
    vecs[15] = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b0, DD,     7'h00, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 48'h77, 7'h15, 1'b1, 1'b0, 1'b1, 48'h77, 7'h15, 1'b1, 2'd1};
    vecs[17] = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b0, 48'h77, 7'h00, 1'b1, 2'd0};
    vecs[18] = '{1'b1, 48'h88, 7'h08, 1'b1, 1'b0, 1'b1, 48'h88, 7'h08, 1'b1, 2'd1};
    vecs[19] = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b1, 1'b0, 48'h88, 7'h00, 1'b1, 2'd0};
    vecs[20] = '{1'b1, 48'h91, 7'h11, 1'b0, 1'b0, 1'b1, 48'h91, 7'h11, 1'b1, 2'd1};
    vecs[21] = '{1'b1, 48'h92, 7'h12, 1'b0, 1'b0, 1'b1, 48'h91, 7'h11, 1'b0, 2'd2};
    vecs[22] = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b1, 48'h92, 7'h12, 1'b1, 2'd1};
    vecs[23] = '{1'b1, 48'h93, 7'h13, 1'b1, 1'b0, 1'b1, 48'h93, 7'h13, 1'b1, 2'd1};
    vecs[24] = '{1'b0, 48'd0,  7'h00, 1'b1, 1'b0, 1'b0, 48'h93, 7'h00, 1'b1, 2'd0};

    // reset held with traffic offered
    in_valid = 1'b1; in_data = A; in_ctrl = 7'h15; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'h00);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; in_ctrl = vecs[i].ic;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      check($sformatf("v%0d_out_data", i),  64'(out_data),  64'(vecs[i].od));
      check($sformatf("v%0d_out_ctrl", i),  64'(out_ctrl),  64'(vecs[i].oc));
      check($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].ir));
      check($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
    end
    flush = 1'b0;

    // asynchronous reset while full, checked before any clock edge
    in_valid = 1'b1; in_data = 48'h5A; in_ctrl = 7'h05; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 48'h5B;
    @(posedge clk); #1;
    check("pre_async_occ", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_occ",       64'(occupancy), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready",  64'(in_ready),  64'd1);
    check("async_out_ctrl",  64'(out_ctrl),  64'h00);
    check("async_out_data",  64'(out_data),  64'd0);
    #2 rst = 1'b1;
    in_valid = 1'b1; in_data = 48'h5C; in_ctrl = 7'h06; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_async_valid", 64'(out_valid), 64'd1);
    check("post_async_data",  64'(out_data),  64'h5C);
    in_valid = 1'b0;

    // bubble value other than zero
    check("bub_empty_ctrl", 64'(b_out_ctrl), 64'h10);
    b_in_valid = 1'b1; b_in_data = 48'h42; b_in_ctrl = 7'h15; b_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bub_full_ctrl",  64'(b_out_ctrl),  64'h15);
    check("bub_full_valid", 64'(b_out_valid), 64'd1);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("bub_drain_ctrl",  64'(b_out_ctrl),  64'h10);
    check("bub_drain_valid", 64'(b_out_valid), 64'd0);

    // random stream on the narrow instance
    begin
      logic [8:0] q[$];
      logic [8:0] got;
      int pushed;
      int cycles;
      pushed = 0;
      cycles = 0;
      while ((pushed < 1000 || q.size() > 0) && cycles < 20000) begin
        s_in_valid  = (pushed < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
        s_out_ready = (pushed < 1000) ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_in_data   = 8'($urandom);
        s_in_ctrl   = 1'($urandom);
        if (s_out_valid && s_out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sweep_extra: got %0h, expected no entry", {s_out_ctrl, s_out_data});
          end else begin
            got = q.pop_front();
            check("sweep_item", 64'({s_out_ctrl, s_out_data}), 64'(got));
          end
        end
        if (s_in_valid && s_in_ready) begin
          q.push_back({s_in_ctrl, s_in_data});
          pushed++;
        end
        @(posedge clk); #1;
        cycles++;
      end
      s_in_valid = 1'b0;
      check("sweep_pushed",  64'(pushed),      64'd1000);
      check("sweep_left",    64'(q.size()),    64'd0);
      check("sweep_occ_end", 64'(s_occupancy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_latch.md
# pipe_stage_skid_latch

Parametrised pipeline-stage register, the generalised successor to the fixed per-field stage latches (e.g. memory→writeback). It carries a DATA_WIDTH×NUM_FIELDS data payload plus a CTRL_WIDTH control vector between two pipeline stages. A valid/ready handshake and a two-entry skid buffer let back-pressure stall the upstream stage without combinational ready paths. Flush squashes in-flight entries, and a bubble value forces control outputs (regWrite, halt, …) to a safe state whenever the stage is empty.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one data field (PC, readData, aluOut).
- NUM_FIELDS, 3, number of data fields; the payload is DATA_WIDTH*NUM_FIELDS bits, field k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- CTRL_WIDTH, 7, control vector width (default packing: memToReg, link, regWrite, halt, writeRegSel[2:0]).
- CTRL_BUBBLE, {CTRL_WIDTH{1'b0}}, control value driven when no valid entry is presented.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry; registered, equals ~skid_valid.
- in_data  in  DATA_WIDTH*NUM_FIELDS  upstream payload.
- in_ctrl  in  CTRL_WIDTH  upstream control.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream consumes the presented entry.
- out_data  out  DATA_WIDTH*NUM_FIELDS  presented payload.
- out_ctrl  out  CTRL_WIDTH  presented control; CTRL_BUBBLE when out_valid=0.
- flush  in  1  synchronous squash of all held entries and of this cycle's input.
- occupancy  out  2  number of held entries, 0–2.

## Operation
- State: main register (main_data, main_ctrl, main_valid) feeds the outputs; skid register (skid_data, skid_ctrl, skid_valid) holds the overflow entry.
- accept = in_valid & in_ready. consume = out_valid & out_ready.
- Priority per edge: reset > flush > normal update.
- flush=1: main_valid←0 and skid_valid←0. The input is dropped even if accept=1, and a consume in the same cycle is still counted by downstream. Data registers hold their values.
- Normal update:
  - Main empty or consume, skid_valid=1: main←skid, skid_valid←0. No input is accepted in this case because in_ready=0.
  - Main empty or consume, skid_valid=0, accept: main←input, main_valid←1.
  - Main empty or consume, no skid, no accept: main_valid←0.
  - Main valid, no consume, accept: skid←input, skid_valid←1. Main is unchanged.
  - Main valid, no consume, no accept: hold.
- out_ctrl = main_valid ? main_ctrl : CTRL_BUBBLE.
- out_data = main_data regardless of valid; it holds the last value after the entry drains.
- occupancy = main_valid + skid_valid.
- Entries leave in arrival order. None are duplicated or lost except by flush.
- Reset values: main_valid=0, skid_valid=0, all data/ctrl registers 0, out_ctrl=CTRL_BUBBLE, in_ready=1, occupancy=0.

## Timing
- Latency: an accepted entry appears on out_* one cycle after the accepting edge when the main register is free.
- Throughput: one entry per cycle while out_ready=1.
- in_ready depends only on registered state; it has no combinational path from out_ready or in_valid.
- out_valid, out_data and out_ctrl are registered, with out_ctrl passing through one mux stage.
- One stall cycle (out_ready=0 while main is valid) absorbs the in-flight entry into skid. in_ready falls on the next cycle.
- in_ready rises the cycle after skid drains into main.
- Full stage (occupancy=2) with out_ready=1 for one cycle gives occupancy 1 and in_ready=1 on the next cycle.
- Reset asserted mid-operation clears all state immediately without waiting for clk. Deassertion is taken synchronously by the first following edge.
- flush and accept in the same cycle: the next cycle shows occupancy=0 and out_ctrl=CTRL_BUBBLE.

## Test plan
- Reset: hold rst=0 with in_valid=1 and clk toggling → out_valid=0, out_ctrl=7'h00, in_ready=1, occupancy=0. After release, the first accepted in_data=48'h1234_5678_9ABC appears on out_data one cycle later with out_valid=1.
- Streaming: out_ready=1, inputs 1,2,3,4 on consecutive cycles → outputs 1,2,3,4 on consecutive cycles; in_ready stays 1 and occupancy stays 1.
- Back-pressure: send A then B while out_ready=0 → occupancy=2, in_ready=0, out shows A. Raise out_ready → A, then B, then out_valid=0. in_ready returns to 1 one cycle after B moves to main.
- Flush while full: occupancy=2, then flush=1 with in_valid=1 (C) → next cycle out_valid=0, occupancy=0, in_ready=1, and C never appears.
- Bubble control: set in_ctrl=7'b0010_101 (regWrite=1) and let the entry drain → while out_valid=0, out_ctrl=CTRL_BUBBLE. Repeat with CTRL_BUBBLE=7'h10 and check out_ctrl=7'h10 when empty.
- Parameter sweep: DATA_WIDTH=8, NUM_FIELDS=1, CTRL_WIDTH=1; run a random valid/ready stream of 1000 items → the output sequence equals the input sequence against a scoreboard.
